paddle_controller: RTL and testbench

//  Upstream feeder of the ball/score stage: produces paddle1_y/paddle2_y (offset below TOP_MARGIN).

---
 rtl/paddle_controller_pkg.sv | 47 ++++
 rtl/paddle_controller_if.sv | 30 +++
 rtl/paddle_controller_debounce.sv | 39 +++
 rtl/paddle_controller.sv | 72 +++++++
 tb/tb_paddle_controller.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/paddle_controller_pkg.sv
// Shared playfield geometry for the paddle, ball and renderer blocks,
// plus the clamped single-step paddle move used by both paddles.
package paddle_controller_pkg;

    localparam int SCREEN_HEIGHT = 480;
    localparam int SCREEN_WIDTH  = 640;
    localparam int TOP_MARGIN    = 25;
    localparam int PADDLE_HEIGHT = 72;
    localparam int BALL_SIZE     = 8;
    localparam int Y_MAX         = SCREEN_HEIGHT - TOP_MARGIN - PADDLE_HEIGHT;
    localparam int Y_CTR         = Y_MAX / 2;

    typedef enum logic [1:0] {
        MOVE_HOLD = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DN   = 2'd2
    } move_e;

    // Both directions pressed cancel out to a hold.
    function automatic move_e decode_move(input logic up, input logic dn);
        move_e mv;
        mv = MOVE_HOLD;
        if (up && !dn) mv = MOVE_UP;
        else if (dn && !up) mv = MOVE_DN;
        return mv;
    endfunction

    // 11-bit arithmetic keeps y+speed from wrapping before the clamp.
    function automatic logic [9:0] step_y(input logic [9:0] y, input move_e mv,
                                          input int unsigned speed);
        logic [10:0] y_w;
        logic [10:0] sum_w;
        logic [10:0] diff_w;
        logic [9:0]  res;
        y_w    = {1'b0, y};
        sum_w  = y_w + 11'(speed);
        diff_w = y_w - 11'(speed);
        res    = y;
        case (mv)
            MOVE_UP: res = (y_w < 11'(speed)) ? 10'd0 : diff_w[9:0];
            MOVE_DN: res = (sum_w > 11'(Y_MAX)) ? 10'(Y_MAX) : sum_w[9:0];
            default: res = y;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/paddle_controller_if.sv
// Control/button/position bundle between the game core and the paddle block.
interface paddle_controller_if;

    logic       refresh_tick;
    logic       game_active;
    logic       center_req;
    logic       ai_mode;
    logic       btn_p1_up;
    logic       btn_p1_down;
    logic       btn_p2_up;
    logic       btn_p2_down;
    logic [9:0] ball_y;
    logic [9:0] paddle1_y;
    logic [9:0] paddle2_y;

    // Single-cycle pulses (refresh_tick, center_req) are sampled on one clk edge;
    // there is no ready/backpressure, the paddle block always accepts them.
    modport master (
        output refresh_tick, game_active, center_req, ai_mode,
        output btn_p1_up, btn_p1_down, btn_p2_up, btn_p2_down, ball_y,
        input  paddle1_y, paddle2_y
    );

    modport slave (
        input  refresh_tick, game_active, center_req, ai_mode,
        input  btn_p1_up, btn_p1_down, btn_p2_up, btn_p2_down, ball_y,
        output paddle1_y, paddle2_y
    );

endinterface

// File: rtl/paddle_controller_debounce.sv
// Two-flop synchroniser followed by a stability counter; the debounced level
// follows the synchronised input only after it has differed for a full count.
module paddle_controller_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_deb
);

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_deb;
    logic [DEBOUNCE_BITS-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (&r_cnt) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/paddle_controller.sv
// Paddle position block: debounced buttons (or AI for paddle 2) move both
// paddles once per refresh_tick, clamped to 0..Y_MAX; center_req recentres.
module paddle_controller
    import paddle_controller_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16,
    parameter int PADDLE_SPEED  = 4,
    parameter int AI_DEADBAND   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    paddle_controller_if.slave bus
);

    logic [3:0]  w_raw;
    logic [3:0]  w_deb;
    logic [9:0]  r_p1_y;
    logic [9:0]  r_p2_y;
    logic [10:0] w_pc;
    logic [10:0] w_bc;
    move_e       w_mv1;
    move_e       w_mv2;
    move_e       w_ai_mv;

    // Index order: p1_up, p1_down, p2_up, p2_down.
    assign w_raw = {bus.btn_p2_down, bus.btn_p2_up, bus.btn_p1_down, bus.btn_p1_up};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        paddle_controller_debounce #(
            .DEBOUNCE_BITS(DEBOUNCE_BITS)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .i_btn  (w_raw[g]),
            .o_deb  (w_deb[g])
        );
    end

    // AI compares paddle and ball centres in absolute screen lines.
    always_comb begin
        w_pc    = {1'b0, r_p2_y} + 11'(TOP_MARGIN + PADDLE_HEIGHT / 2);
        w_bc    = {1'b0, bus.ball_y} + 11'(BALL_SIZE / 2);
        w_ai_mv = MOVE_HOLD;
        if ((w_bc + 11'(AI_DEADBAND)) < w_pc) begin
            w_ai_mv = MOVE_UP;
        end else if (w_bc > (w_pc + 11'(AI_DEADBAND))) begin
            w_ai_mv = MOVE_DN;
        end
    end

    always_comb begin
        w_mv1 = decode_move(w_deb[0], w_deb[1]);
        w_mv2 = bus.ai_mode ? w_ai_mv : decode_move(w_deb[2], w_deb[3]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_y <= 10'(Y_CTR);
            r_p2_y <= 10'(Y_CTR);
        end else if (bus.center_req) begin
            r_p1_y <= 10'(Y_CTR);
            r_p2_y <= 10'(Y_CTR);
        end else if (bus.refresh_tick && bus.game_active) begin
            r_p1_y <= step_y(r_p1_y, w_mv1, PADDLE_SPEED);
            r_p2_y <= step_y(r_p2_y, w_mv2, PADDLE_SPEED);
        end
    end

    assign bus.paddle1_y = r_p1_y;
    assign bus.paddle2_y = r_p2_y;

endmodule

// File: tb/tb_paddle_controller.sv
// Directed bench for paddle_controller with a 16-clk debounce window.
module tb_paddle_controller;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_miss;
  int   exp1;
  int   exp2;

  paddle_controller_if bus ();

  paddle_controller #(
    .DEBOUNCE_BITS(4),
    .PADDLE_SPEED (4),
    .AI_DEADBAND  (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    bus.refresh_tick = 1'b1;
    @(negedge clk);
    bus.refresh_tick = 1'b0;
  endtask

  // scoreboard
  task automatic check_val(input string tag, input logic [9:0] got, input int exp);
    n_vec++;
    if (got !== 10'(exp)) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_up(input int y);
    return (y < 4) ? 0 : y - 4;
  endfunction

  function automatic int exp_dn(input int y);
    return (y + 4 > 383) ? 383 : y + 4;
  endfunction

  function automatic int exp_ai(input int y, input int ball);
    int pc;
    int bc;
    pc = y + 25 + 36;
    bc = ball + 4;
    if (bc + 4 < pc) return exp_up(y);
    if (bc > pc + 4) return exp_dn(y);
    return y;
  endfunction

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset_n          = 1'b0;
    bus.refresh_tick = 1'b0;
    bus.game_active  = 1'b1;
    bus.center_req   = 1'b0;
    bus.ai_mode      = 1'b0;
    bus.btn_p1_up    = 1'b0;
    bus.btn_p1_down  = 1'b0;
    bus.btn_p2_up    = 1'b0;
    bus.btn_p2_down  = 1'b0;
    bus.ball_y       = 10'd0;

    #12;
    check_val("rst_p1", bus.paddle1_y, 191);
    check_val("rst_p2", bus.paddle2_y, 191);
    @(negedge clk);
    reset_n = 1'b1;
    step(2);
    check_val("post_rst_p1", bus.paddle1_y, 191);
    check_val("post_rst_p2", bus.paddle2_y, 191);

    repeat (5) tick();
    check_val("idle_p1", bus.paddle1_y, 191);
    check_val("idle_p2", bus.paddle2_y, 191);

    // 10-clk glitch must not reach the debounced level
    bus.btn_p1_up = 1'b1;
    step(10);
    bus.btn_p1_up = 1'b0;
    step(20);
    tick();
    check_val("glitch_p1", bus.paddle1_y, 191);

    // deb rises on the 18th edge after the press
    bus.btn_p1_up = 1'b1;
    step(16);
    tick();
    check_val("p1_before_deb", bus.paddle1_y, 191);
    step(1);
    tick();
    exp1 = 187;
    check_val("p1_first_move", bus.paddle1_y, exp1);
    for (int i = 2; i <= 50; i++) begin
      tick();
      exp1 = exp_up(exp1);
      check_val($sformatf("p1_up_t%0d", i), bus.paddle1_y, exp1);
      if (i == 48) check_val("p1_top_at_48", bus.paddle1_y, 0);
    end
    bus.btn_p1_up = 1'b0;
    step(20);

    bus.btn_p2_down = 1'b1;
    step(20);
    exp2 = 191;
    for (int i = 1; i <= 50; i++) begin
      tick();
      exp2 = exp_dn(exp2);
      check_val($sformatf("p2_dn_t%0d", i), bus.paddle2_y, exp2);
      if (i == 48) check_val("p2_bottom_at_48", bus.paddle2_y, 383);
    end
    check_val("p1_still_top", bus.paddle1_y, 0);

    bus.btn_p2_up = 1'b1;
    step(20);
    repeat (3) tick();
    check_val("p2_both_hold", bus.paddle2_y, 383);
    bus.btn_p2_up   = 1'b0;
    bus.btn_p2_down = 1'b0;
    step(20);

    bus.game_active = 1'b0;
    bus.btn_p1_down = 1'b1;
    step(20);
    repeat (3) tick();
    check_val("frozen_p1", bus.paddle1_y, 0);
    check_val("frozen_p2", bus.paddle2_y, 383);
    bus.game_active = 1'b1;
    tick();
    check_val("resume_p1_a", bus.paddle1_y, 4);
    tick();
    check_val("resume_p1_b", bus.paddle1_y, 8);

    bus.center_req   = 1'b1;
    bus.refresh_tick = 1'b1;
    @(negedge clk);
    bus.center_req   = 1'b0;
    bus.refresh_tick = 1'b0;
    check_val("center_p1", bus.paddle1_y, 191);
    check_val("center_p2", bus.paddle2_y, 191);
    bus.btn_p1_down = 1'b0;
    step(20);

    bus.ai_mode = 1'b1;
    bus.ball_y  = 10'd100;
    exp2 = 191;
    for (int i = 1; i <= 40; i++) begin
      tick();
      exp2 = exp_ai(exp2, 100);
      check_val($sformatf("ai_up_t%0d", i), bus.paddle2_y, exp2);
    end
    check_val("ai_hold_47", bus.paddle2_y, 47);
    check_val("ai_p1_idle", bus.paddle1_y, 191);

    bus.center_req = 1'b1;
    @(negedge clk);
    bus.center_req = 1'b0;
    check_val("ai_center_p2", bus.paddle2_y, 191);
    bus.btn_p2_down = 1'b1;
    step(20);
    exp2 = 191;
    for (int i = 1; i <= 40; i++) begin
      tick();
      exp2 = exp_ai(exp2, 100);
      check_val($sformatf("ai_btn_t%0d", i), bus.paddle2_y, exp2);
    end
    check_val("ai_btn_ignored", bus.paddle2_y, 47);
    bus.btn_p2_down = 1'b0;

    bus.ball_y = 10'd400;
    exp2 = 47;
    for (int i = 1; i <= 80; i++) begin
      tick();
      exp2 = exp_ai(exp2, 400);
      check_val($sformatf("ai_dn_t%0d", i), bus.paddle2_y, exp2);
    end
    check_val("ai_hold_339", bus.paddle2_y, 339);

    // asynchronous reset in the middle of motion
    bus.btn_p1_up = 1'b1;
    step(20);
    tick();
    tick();
    check_val("p1_pre_rst", bus.paddle1_y, 183);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_p1", bus.paddle1_y, 191);
    check_val("async_rst_p2", bus.paddle2_y, 191);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_val("rst_deb_cleared", bus.paddle1_y, 191);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
